// File: rtl/ccx_rst_pkg.sv
// Shared types and defaults for the CCX cluster reset sequencer.
package ccx_rst_pkg;

    // Sequencer states, see the table in ccx_rst_seq for their meaning.
    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_DBG_REL = 2'd1,
        ST_RUN     = 2'd2,
        ST_DBGI    = 2'd3
    } ccx_rst_state_e;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_MIN_ASSERT  = 8;
    localparam int DEF_DBG_DLY     = 4;

    // Larger of two integers; used to size the shared counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : ccx_rst_pkg

// File: rtl/ccx_rst_sync.sv
// N-flop synchronizer with a selectable asynchronous reset value.
module ccx_rst_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic rclk,
    input  logic arst_l,
    input  logic d,
    output logic q
);

    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("ccx_rst_sync: STAGES must be at least 2");
        end
    endgenerate

    logic [STAGES-1:0] chain_q;

    // Shift the asynchronous input through the chain; reset presets every stage.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            chain_q <= {STAGES{RST_VAL}};
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d};
        end
    end

    assign q = chain_q[STAGES-1];

endmodule : ccx_rst_sync

// File: rtl/ccx_rst_seq.sv
// CCX cluster reset sequencer: synchronizes the cluster reset and the global
// reset / debug-init requests, then releases adbginit_l before rst_l with
// counted minimum low widths.
//
// state   | meaning
// --------+---------------------------------------------------------------
// HOLD    | adbginit_l=0, rst_l=0; count MIN_ASSERT clean cycles
// DBG_REL | adbginit_l=1, rst_l=0; wait DBG_DLY cycles before rst_l release
// RUN     | both released, rst_done=1
// DBGI    | adbginit_l=0, rst_l=1; debug init held for MIN_ASSERT clean cycles
module ccx_rst_seq
    import ccx_rst_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int MIN_ASSERT  = DEF_MIN_ASSERT,
    parameter int DBG_DLY     = DEF_DBG_DLY
) (
    input  logic rclk,
    input  logic arst_l,
    input  logic grst_l,
    input  logic gdbginit_l,
    input  logic se,
    output logic rst_l,
    output logic adbginit_l,
    output logic se_out,
    output logic rst_done
);

    localparam int CNT_TOP = max_int(MIN_ASSERT, DBG_DLY);
    localparam int CW      = $clog2(CNT_TOP + 1);

    localparam logic [CW-1:0] MIN_C = CW'(MIN_ASSERT);
    localparam logic [CW-1:0] DLY_C = CW'(DBG_DLY);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("ccx_rst_seq: SYNC_STAGES must be at least 2");
        end
        if (MIN_ASSERT < 1) begin : g_bad_min
            $error("ccx_rst_seq: MIN_ASSERT must be at least 1");
        end
        if (DBG_DLY < 1) begin : g_bad_dly
            $error("ccx_rst_seq: DBG_DLY must be at least 1");
        end
    endgenerate

    logic rel_s;
    logic grst_s;
    logic gdbg_s;

    // Internal reset release: the chain resets to 0 and fills with 1s.
    ccx_rst_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_arst (
        .rclk   (rclk),
        .arst_l (arst_l),
        .d      (1'b1),
        .q      (rel_s)
    );

    // Request synchronizers reset to 1 so reset itself reads as "no request".
    ccx_rst_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_grst (
        .rclk   (rclk),
        .arst_l (arst_l),
        .d      (grst_l),
        .q      (grst_s)
    );

    ccx_rst_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_gdbg (
        .rclk   (rclk),
        .arst_l (arst_l),
        .d      (gdbginit_l),
        .q      (gdbg_s)
    );

    ccx_rst_state_e  state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic            rst_l_d, adbg_d, done_d;

    // Saturating increment so the counter can never wrap back below a threshold.
    assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    // Next state and counter; scan enable freezes both.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!se) begin
            case (state_q)
                ST_HOLD: begin
                    if (!grst_s) begin
                        cnt_d = '0;
                    end else if (cnt_q == MIN_C) begin
                        state_d = ST_DBG_REL;
                        cnt_d   = '0;
                    end else if (rel_s) begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_DBG_REL: begin
                    // The releasing cycle counts toward the delay, so rst_l
                    // follows adbginit_l by exactly DBG_DLY edges.
                    if (!grst_s) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end else if (cnt_inc == DLY_C) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_RUN: begin
                    if (!grst_s) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end else if (!gdbg_s) begin
                        state_d = ST_DBGI;
                        cnt_d   = '0;
                    end
                end
                ST_DBGI: begin
                    if (!grst_s) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end else if (!gdbg_s) begin
                        cnt_d = '0;
                    end else if (cnt_q == MIN_C) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output decode from the next state, registered alongside the state.
    always_comb begin
        rst_l_d = 1'b0;
        adbg_d  = 1'b0;
        done_d  = 1'b0;
        case (state_d)
            ST_DBG_REL: adbg_d = 1'b1;
            ST_RUN: begin
                adbg_d  = 1'b1;
                rst_l_d = 1'b1;
                done_d  = 1'b1;
            end
            ST_DBGI:    rst_l_d = 1'b1;
            default: begin
                rst_l_d = 1'b0;
                adbg_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State, counter and output registers; arst_l forces HOLD outputs at once.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            state_q    <= ST_HOLD;
            cnt_q      <= '0;
            rst_l      <= 1'b0;
            adbginit_l <= 1'b0;
            rst_done   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rst_l      <= rst_l_d;
            adbginit_l <= adbg_d;
            rst_done   <= done_d;
        end
    end

    assign se_out = se;

endmodule : ccx_rst_seq

// File: tb/tb_ccx_rst_seq.sv
// Scoreboard bench for ccx_rst_seq: stimulus queues expected output changes
// (edge number + {rst_l, adbginit_l, rst_done}); a monitor pops one entry per
// observed change.
module tb_ccx_rst_seq;

    logic rclk = 1'b0;
    logic arst_l, grst_l, gdbginit_l, se;
    logic rst_l, adbginit_l, se_out, rst_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int       cyc;
        logic [2:0] val;
    } exp_t;

    exp_t sb[$];

    ccx_rst_seq dut (
        .rclk       (rclk),
        .arst_l     (arst_l),
        .grst_l     (grst_l),
        .gdbginit_l (gdbginit_l),
        .se         (se),
        .rst_l      (rst_l),
        .adbginit_l (adbginit_l),
        .se_out     (se_out),
        .rst_done   (rst_done)
    );

    always #5 rclk = ~rclk;

    always @(posedge rclk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge rclk);
        #1;
    endtask

    task automatic push(input int c, input logic [2:0] v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input string name, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at edge %0d", name, got, exp, cyc);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at edge %0d", name, got, exp, cyc);
        end
    endtask

    // Monitor: every change of the sequenced outputs must match the next queued event.
    logic [2:0] prev_out = 3'b000;
    logic [2:0] cur_out;
    exp_t       mon_e;
    always @(negedge rclk) begin
        cur_out = {rst_l, adbginit_l, rst_done};
        if (cur_out !== prev_out) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change: got %b (was %b) at edge %0d, none expected",
                         cur_out, prev_out, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.cyc != cyc || mon_e.val !== cur_out) begin
                    errors++;
                    $display("FAIL seq_event: got %b at edge %0d, expected %b at edge %0d",
                             cur_out, cyc, mon_e.val, mon_e.cyc);
                end
            end
            prev_out = cur_out;
        end
    end

    int p, r;

    initial begin
        arst_l     = 1'b0;
        grst_l     = 1'b1;
        gdbginit_l = 1'b1;
        se         = 1'b0;
        tick(3);
        check("reset_outputs", {rst_l, adbginit_l, rst_done}, 3'b000);

        // Power-on release: adbginit_l at edge 11, rst_l/rst_done at edge 15.
        arst_l = 1'b1;
        r = cyc;
        push(r + 11, 3'b010);
        push(r + 15, 3'b111);
        tick(10);
        check("poweron_still_held", {rst_l, adbginit_l, rst_done}, 3'b000);
        tick(10);
        check("poweron_run", {rst_l, adbginit_l, rst_done}, 3'b111);

        // grst_l low for 20 cycles from RUN.
        grst_l = 1'b0;
        p = cyc;
        push(p + 3, 3'b000);
        tick(20);
        grst_l = 1'b1;
        r = cyc;
        push(r + 11, 3'b010);
        push(r + 15, 3'b111);
        tick(20);

        // One-cycle grst_l pulse still gives the full minimum sequence.
        grst_l = 1'b0;
        p = cyc;
        push(p + 3, 3'b000);
        tick(1);
        grst_l = 1'b1;
        r = cyc;
        push(r + 11, 3'b010);
        push(r + 15, 3'b111);
        tick(20);

        // One-cycle gdbginit_l pulse: adbginit_l low for 9 cycles, rst_l stays 1.
        gdbginit_l = 1'b0;
        p = cyc;
        push(p + 3, 3'b100);
        push(p + 12, 3'b111);
        tick(1);
        gdbginit_l = 1'b1;
        tick(15);

        // Both requests on the same edge: reset wins, DBGI never seen.
        grst_l     = 1'b0;
        gdbginit_l = 1'b0;
        p = cyc;
        push(p + 3, 3'b000);
        tick(5);
        grst_l     = 1'b1;
        gdbginit_l = 1'b1;
        r = cyc;
        push(r + 11, 3'b010);
        push(r + 15, 3'b111);
        tick(20);

        // arst_l from RUN, then again in the middle of DBG_REL.
        arst_l = 1'b0;
        push(cyc, 3'b000);
        #1;
        check("arst_async_run", {rst_l, adbginit_l, rst_done}, 3'b000);
        tick(2);
        arst_l = 1'b1;
        r = cyc;
        push(r + 11, 3'b010);
        tick(12);
        check("in_dbg_rel", {rst_l, adbginit_l, rst_done}, 3'b010);
        arst_l = 1'b0;
        push(cyc, 3'b000);
        #1;
        check("arst_async_dbgrel", {rst_l, adbginit_l, rst_done}, 3'b000);
        tick(2);
        arst_l = 1'b1;
        r = cyc;
        push(r + 11, 3'b010);
        push(r + 15, 3'b111);
        tick(20);

        // Scan enable for 5 cycles during HOLD counting delays release by 5.
        arst_l = 1'b0;
        push(cyc, 3'b000);
        tick(2);
        arst_l = 1'b1;
        r = cyc;
        tick(4);
        se = 1'b1;
        #1;
        check1("se_out_high", se_out, 1'b1);
        tick(5);
        se = 1'b0;
        #1;
        check1("se_out_low", se_out, 1'b0);
        push(r + 16, 3'b010);
        push(r + 20, 3'b111);
        tick(25);
        check("se_final_run", {rst_l, adbginit_l, rst_done}, 3'b111);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_events: %0d expected changes never seen, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ccx_rst_seq
